uart_tx_engine_cfg: RTL

Runtime-configurable UART transmit engine. It is the successor to the fixed 8N1 transmitter and adds selectable data width (5..DATA_W_MAX), optional even/odd parity, 1 or 2 stop bits, line-break generation, and a frame-done pulse. It pulls bytes from the TX FIFO and serialises them LSB-first. Bit timing is derived internally from the shared oversampling tick, so no separate baud divider instance is needed.

---
 rtl/uart_tx_engine_cfg_if.sv | 26 ++
 rtl/uart_tx_engine_cfg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine_cfg_if.sv
// TX FIFO read-side handshake between the FIFO and the UART transmit engine.
// The engine side initiates reads (master); the FIFO side answers them (slave).
interface uart_tx_engine_cfg_if #(
  parameter int unsigned DATA_W_MAX = 9
) ();

  logic                  tx_fifo_empty_i;
  logic                  tx_fifo_valid_i;
  logic [DATA_W_MAX-1:0] tx_fifo_data_i;
  logic                  tx_fifo_ren_o;

  modport master (
    input  tx_fifo_empty_i,
    input  tx_fifo_valid_i,
    input  tx_fifo_data_i,
    output tx_fifo_ren_o
  );

  modport slave (
    output tx_fifo_empty_i,
    output tx_fifo_valid_i,
    output tx_fifo_data_i,
    input  tx_fifo_ren_o
  );

endinterface

// File: rtl/uart_tx_engine_cfg.sv
// Runtime-configurable UART transmitter: 5..DATA_W_MAX data bits, optional parity,
// 1/2 stop bits and break generation, timed from a shared oversampling tick.
module uart_tx_engine_cfg #(
  parameter int unsigned OSR        = 16,
  parameter int unsigned DATA_W_MAX = 9
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        osr_tick_i,
  uart_tx_engine_cfg_if.master        fifo,
  input  logic                        tx_en_i,
  input  logic [3:0]                  data_bits_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  input  logic                        stop2_i,
  input  logic                        break_i,
  output logic                        tx_busy_o,
  output logic                        tx_done_o,
  output logic                        transmit_bit_o
);

  localparam int unsigned OSR_W = $clog2(OSR);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;

  state_t                state_q, state_d;
  logic [OSR_W-1:0]      osr_q, osr_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [CNT_W-1:0]      width_q, width_d;
  logic [DATA_W_MAX-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  line_q, line_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ren_q, ren_d;

  logic [CNT_W-1:0]      width_c;
  logic                  par_c;
  logic                  bit_end_c;

  // Clamp requested width and compute parity over the selected bits only
  always_comb begin
    width_c = data_bits_i;
    if (data_bits_i < CNT_W'(5)) begin
      width_c = CNT_W'(5);
    end else if (data_bits_i > CNT_W'(DATA_W_MAX)) begin
      width_c = CNT_W'(DATA_W_MAX);
    end
    par_c = parity_odd_i;
    for (int i = 0; i < int'(DATA_W_MAX); i++) begin
      if (CNT_W'(i) < width_c) begin
        par_c = par_c ^ fifo.tx_fifo_data_i[i];
      end
    end
  end

  assign bit_end_c = osr_tick_i && (osr_q == OSR_W'(OSR - 1));

  always_comb begin
    state_d   = state_q;
    osr_d     = osr_q;
    bit_d     = bit_q;
    width_d   = width_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    par_bit_d = par_bit_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ren_d     = 1'b0;

    // Bit timer idles in IDLE/FETCH and is held clear for the whole break
    if ((state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_BREAK) || bit_end_c) begin
      osr_d = '0;
    end else if (osr_tick_i) begin
      osr_d = osr_q + OSR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        line_d = 1'b1;
        if (break_i) begin
          state_d = S_BREAK;
          busy_d  = 1'b1;
          line_d  = 1'b0;
        end else if (tx_en_i && !fifo.tx_fifo_empty_i) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          ren_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (fifo.tx_fifo_valid_i) begin
          shreg_d   = fifo.tx_fifo_data_i;
          width_d   = width_c;
          par_en_d  = parity_en_i;
          stop2_d   = stop2_i;
          par_bit_d = par_c;
          bit_d     = '0;
          state_d   = S_START;
          line_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          line_d  = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_q == (width_q - CNT_W'(1))) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = S_STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + CNT_W'(1);
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          bit_d   = '0;
          line_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_d = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            line_d  = 1'b1;
          end
        end
      end
      S_BREAK: begin
        line_d = 1'b0;
        if (!break_i) begin
          state_d = S_MARK;
          line_d  = 1'b1;
        end
      end
      S_MARK: begin
        if (bit_end_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      osr_q     <= '0;
      bit_q     <= '0;
      width_q   <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ren_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      osr_q     <= osr_d;
      bit_q     <= bit_d;
      width_q   <= width_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ren_q     <= ren_d;
    end
  end

  assign fifo.tx_fifo_ren_o = ren_q;
  assign tx_busy_o          = busy_q;
  assign tx_done_o          = done_q;
  assign transmit_bit_o     = line_q;

endmodule
